// File: rtl/norm_pkg.sv
// Shared definitions for the batch-normalisation stage.
package norm_pkg;

    localparam int DWIDTH      = 8;
    localparam int DESIGN_SIZE = 16;
    localparam int MASK_WIDTH  = 16;

    // Signed 8-bit clamp limits for the scaled result.
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUB   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } norm_state_e;

endpackage

// File: rtl/norm_lane.sv
// One lane: captured input, (x - mean) register, saturating scale, result
// register, and the mask/bypass output selection.
module norm_lane
    import norm_pkg::*;
#(
    parameter int DW = norm_pkg::DWIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,     // capture x this edge
    input  logic          sub_i,      // register x - mean this edge
    input  logic          scale_i,    // register saturated product this edge
    input  logic          sel_i,      // 1 = show result, 0 = pass input through
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] mean_i,
    input  logic [DW-1:0] inv_var_i,
    output logic [DW-1:0] y_o
);

    localparam int PW = 2*DW + 2;
    localparam logic signed [PW-1:0] P_MAX = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] P_MIN = PW'(SAT_MIN);

    logic [DW-1:0]        x_q;
    logic signed [DW:0]   d_q, d_d;
    logic [DW-1:0]        res_q, res_d;
    logic signed [PW-1:0] prod;

    // Difference is one bit wider so x - mean never wraps.
    always_comb begin
        d_d = $signed({x_q[DW-1], x_q}) - $signed({mean_i[DW-1], mean_i});
    end

    // Scale is unsigned, so it enters the multiply with a zero sign bit.
    always_comb begin
        prod  = PW'(d_q) * PW'($signed({1'b0, inv_var_i}));
        res_d = prod[DW-1:0];
        if (prod > P_MAX)      res_d = DW'(SAT_MAX);
        else if (prod < P_MIN) res_d = DW'(SAT_MIN);
    end

    // Lane pipeline registers, each advanced by its FSM strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            d_q   <= '0;
            res_q <= '0;
        end else begin
            if (load_i)  x_q   <= x_i;
            if (sub_i)   d_q   <= d_d;
            if (scale_i) res_q <= res_d;
        end
    end

    // Masked or disabled lanes see the live input.
    always_comb begin
        y_o = sel_i ? res_q : x_i;
    end

endmodule

// File: rtl/norm.sv
// Batch-normalisation stage: FSM and captured mean/inv_var shared by
// DESIGN_SIZE lane instances.
module norm #(
    parameter int DWIDTH      = norm_pkg::DWIDTH,
    parameter int DESIGN_SIZE = norm_pkg::DESIGN_SIZE,
    parameter int MASK_WIDTH  = norm_pkg::MASK_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_norm,
    input  logic [DWIDTH-1:0]             mean,
    input  logic [DWIDTH-1:0]             inv_var,
    input  logic                          in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_data_available,
    output logic                          done_norm
);

    import norm_pkg::*;

    norm_state_e       state_q, state_d;
    logic [DWIDTH-1:0] mean_q, inv_var_q;
    logic              done_q, done_d;
    logic              odav_q;
    logic              load, sub, scale;

    // Next state and lane strobes; dropping enable aborts to IDLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sub     = 1'b0;
        scale   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_norm && in_data_available) begin
                    load    = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (!enable_norm) state_d = IDLE;
                else begin
                    sub     = 1'b1;
                    state_d = SCALE;
                end
            end
            SCALE: begin
                if (!enable_norm) state_d = IDLE;
                else begin
                    scale   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = enable_norm;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured operands and the registered completion flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mean_q    <= '0;
            inv_var_q <= '0;
            done_q    <= 1'b0;
            odav_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            odav_q  <= done_d;
            if (load) begin
                mean_q    <= mean;
                inv_var_q <= inv_var;
            end
        end
    end

    // Bypass makes availability follow the input; completion is suppressed.
    always_comb begin
        out_data_available = enable_norm ? odav_q : in_data_available;
        done_norm          = enable_norm & done_q;
    end

    for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
        norm_lane #(.DW(DWIDTH)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load_i    (load),
            .sub_i     (sub),
            .scale_i   (scale),
            .sel_i     (enable_norm & validity_mask[i]),
            .x_i       (inp_data[i*DWIDTH +: DWIDTH]),
            .mean_i    (mean_q),
            .inv_var_i (inv_var_q),
            .y_o       (out_data[i*DWIDTH +: DWIDTH])
        );
    end

endmodule

// File: tb/tb_norm.sv
// Scoreboard bench for norm: stimulus queues expected vectors, a negedge
// monitor compares them whenever the DUT flags an output.
module tb_norm;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable_norm;
    logic [7:0]   mean, inv_var;
    logic         in_data_available;
    logic [127:0] inp_data;
    logic [15:0]  validity_mask;
    logic [127:0] out_data;
    logic         out_data_available;
    logic         done_norm;

    typedef struct {
        logic [127:0] data;
        int           cyc;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    norm dut (
        .clk                (clk),
        .reset              (reset),
        .enable_norm        (enable_norm),
        .mean               (mean),
        .inv_var            (inv_var),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_norm          (done_norm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every flagged output must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (out_data_available || done_norm)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: cyc %0d avail %b done %b", cyc, out_data_available, done_norm);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("done_norm", {127'b0, done_norm}, {127'b0, e.done});
                chk("avail", {127'b0, out_data_available}, 128'd1);
                chk("cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // Issue one normalised vector at the current cycle (called at posedge+#1).
    task automatic send(input logic [7:0] m, input logic [7:0] iv, input logic [15:0] msk,
                        input logic [127:0] d, input logic [127:0] exp);
        exp_t e;
        enable_norm       = 1'b1;
        mean              = m;
        inv_var           = iv;
        validity_mask     = msk;
        inp_data          = d;
        in_data_available = 1'b1;
        e.data = exp; e.cyc = cyc + 4; e.done = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_data_available = 1'b0;
        mean              = 8'h7F;   // post-capture changes must not matter
        inv_var           = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   c;
        reset             = 1'b1;
        enable_norm       = 1'b1;
        mean              = '0;
        inv_var           = '0;
        in_data_available = 1'b0;
        inp_data          = rep(8'h55);
        validity_mask     = 16'hFFFF;
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_data", out_data, 128'd0);
        chk("reset_done", {127'b0, done_norm}, 128'd0);
        chk("reset_avail", {127'b0, out_data_available}, 128'd0);
        reset = 1'b0;

        // Bypass: output tracks input in the same cycle, no done pulse.
        @(posedge clk); #1;
        enable_norm       = 1'b0;
        in_data_available = 1'b1;
        inp_data          = rep(8'h42);
        e.data = rep(8'h42); e.cyc = cyc; e.done = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        validity_mask = 16'h0000;
        inp_data      = rep(8'h9C);
        e.data = rep(8'h9C); e.cyc = cyc; e.done = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        in_data_available = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic, mask, and saturation vectors.
        send(8'h10, 8'h02, 16'hFFFF, rep(8'h20), rep(8'h20));
        send(8'h10, 8'h02, 16'h5555, rep(8'h30), {8{8'h30, 8'h40}});
        send(8'h10, 8'h02, 16'hFFFF, rep(8'h50), rep(8'h7F));
        send(8'h10, 8'h04, 16'hFFFF, rep(8'h80), rep(8'h80));
        send(8'h10, 8'h03, 16'hFFFF, rep(8'h08), rep(8'hE8));
        send(8'h10, 8'h03, 16'hFFFF, {8{8'h08, 8'h50}}, {8{8'hE8, 8'h7F}});

        // Streaming: continuous valid input gives a pulse every 4 cycles.
        @(posedge clk); #1;
        enable_norm       = 1'b1;
        mean              = 8'hF0;   // -16
        inv_var           = 8'h01;
        validity_mask     = 16'hFFFF;
        inp_data          = rep(8'h10);
        in_data_available = 1'b1;
        c = cyc;
        for (int k = 1; k <= 3; k++) begin
            e.data = rep(8'h20); e.cyc = c + 4*k; e.done = 1'b1;
            sb.push_back(e);
        end
        repeat (9) @(posedge clk);
        #1;
        in_data_available = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Abort in SCALE: no pulse, and a new vector is accepted immediately.
        enable_norm       = 1'b1;
        mean              = 8'h00;
        inv_var           = 8'h01;
        inp_data          = rep(8'h11);
        in_data_available = 1'b1;
        @(posedge clk); #1;          // SUB
        in_data_available = 1'b0;
        @(posedge clk); #1;          // SCALE
        enable_norm = 1'b0;
        @(posedge clk); #1;          // must be IDLE now
        send(8'h10, 8'h02, 16'hFFFF, rep(8'h50), rep(8'h7F));

        // Reset during SUB clears outputs and results at once.
        enable_norm       = 1'b1;
        mean              = 8'h10;
        inv_var           = 8'h02;
        validity_mask     = 16'hFFFF;
        inp_data          = rep(8'h20);
        in_data_available = 1'b1;
        @(posedge clk); #1;          // SUB
        in_data_available = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_done", {127'b0, done_norm}, 128'd0);
        chk("rst_mid_avail", {127'b0, out_data_available}, 128'd0);
        chk("rst_mid_result", out_data, 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(8'h10, 8'h02, 16'hFFFF, rep(8'h20), rep(8'h20));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
